// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the MCP23S17-style SPI register-file slave.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        SSIdle,
        SSOpcode,
        SSAddr,
        SSData,
        SSIgnore
    } SlaveRegState;

    localparam logic [3:0] OPCODE_PREFIX = 4'b0100;

    localparam logic [7:0] IODIRA = 8'h00;
    localparam logic [7:0] IOCON  = 8'h0A;
    localparam logic [7:0] GPIOA  = 8'h12;

    function automatic logic opcode_match(input logic [7:0] op, input logic [2:0] hw_addr);
        return (op[7:4] == OPCODE_PREFIX) && (op[3:1] == hw_addr);
    endfunction

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between an SPI master and the register-file slave.
interface spi_slave_regfile_if;
    logic spiClk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output spiClk, output cs, output mosi, input miso);
    modport slave  (input spiClk, input cs, input mosi, output miso);
endinterface

// File: rtl/CDCSynchron.sv
// Two-flop synchroniser for a single asynchronous input.
module CDCSynchron #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/spi_byte_shifter.sv
// Byte-level SPI shifter: MSB-first rx on sample strobes, tx load/shift on shift strobes.
module spi_byte_shifter (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       sample_i,
    input  logic       shift_i,
    input  logic       mosi_i,
    input  logic       load_en_i,
    input  logic [7:0] load_data_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o,
    output logic       load_slot_o,
    output logic       tx_msb_o,
    output logic [2:0] bit_cnt_o
);
    logic [2:0] bit_cnt_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic       byte_end_q;

    assign byte_done_o = sample_i && (bit_cnt_q == 3'd7);
    assign rx_byte_o   = {rx_q, mosi_i};
    // The first falling edge after a completed byte is the reload slot.
    assign load_slot_o = shift_i && byte_end_q;
    assign tx_msb_o    = tx_q[7];
    assign bit_cnt_o   = bit_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            byte_end_q <= 1'b0;
        end else if (clear_i) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            byte_end_q <= 1'b0;
        end else begin
            if (sample_i) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_q      <= rx_byte_o[6:0];
            end
            if (byte_done_o) begin
                byte_end_q <= 1'b1;
            end else if (shift_i) begin
                byte_end_q <= 1'b0;
            end
            if (load_slot_o && load_en_i) begin
                tx_q <= load_data_i;
            end else if (shift_i) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with an NUM_REGS x 8 register file, shared with a sysClk host port.
module spi_slave_regfile
    import spi_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 22,
    parameter logic [2:0]  HW_ADDR   = 3'b000,
    parameter bit          AUTO_INC  = 1'b1,
    parameter logic [7:0]  REG_RESET = 8'h00
) (
    input  logic                sysClk,
    input  logic                reset,
    spi_slave_regfile_if.slave  spi,
    input  logic [7:0]          host_addr_i,
    output logic [7:0]          host_rdata_o,
    input  logic                host_we_i,
    input  logic [7:0]          host_wdata_i,
    output logic                wr_stb_o,
    output logic [7:0]          wr_addr_o,
    output logic [7:0]          wr_data_o,
    output logic                busy_o,
    output logic                frame_err_o
);
    localparam logic [8:0] LAST_IDX = 9'(NUM_REGS - 1);

    SlaveRegState state_q, state_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall, active;
    logic       byte_done, load_slot, tx_msb;
    logic [7:0] rx_byte;
    logic [2:0] bit_cnt;
    logic [7:0] addr_q, addr_next, rd_data;
    logic       rw_q, wr_stb_q, frame_err_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic       spi_we, addr_load, addr_adv, rw_load, tx_load_en, frame_err_d;
    logic [7:0] regs_q [NUM_REGS];

    CDCSynchron #(.RESET_VAL(1'b0)) u_sync_sclk (.clk_i(sysClk), .rst_n_i(reset), .async_i(spi.spiClk), .sync_o(sclk_s));
    // cs syncs to 0 so a /CS held low across reset release is not seen as a fall.
    CDCSynchron #(.RESET_VAL(1'b0)) u_sync_cs   (.clk_i(sysClk), .rst_n_i(reset), .async_i(spi.cs),     .sync_o(cs_s));
    CDCSynchron #(.RESET_VAL(1'b0)) u_sync_mosi (.clk_i(sysClk), .rst_n_i(reset), .async_i(spi.mosi),   .sync_o(mosi_s));

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign active    = ~cs_s && (state_q != SSIdle);

    spi_byte_shifter u_shifter (
        .clk_i       (sysClk),
        .rst_n_i     (reset),
        .clear_i     (cs_fall | cs_rise),
        .sample_i    (sclk_rise & active),
        .shift_i     (sclk_fall & active),
        .mosi_i      (mosi_s),
        .load_en_i   (tx_load_en),
        .load_data_i (rd_data),
        .rx_byte_o   (rx_byte),
        .byte_done_o (byte_done),
        .load_slot_o (load_slot),
        .tx_msb_o    (tx_msb),
        .bit_cnt_o   (bit_cnt)
    );

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) state_q <= SSIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = SSIdle;
        end else if (cs_fall) begin
            state_d = SSOpcode;
        end else if (byte_done) begin
            case (state_q)
                SSOpcode: state_d = opcode_match(rx_byte, HW_ADDR) ? SSAddr : SSIgnore;
                SSAddr:   state_d = SSData;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        spi_we      = 1'b0;
        addr_load   = 1'b0;
        addr_adv    = 1'b0;
        rw_load     = 1'b0;
        tx_load_en  = 1'b0;
        frame_err_d = cs_rise && (bit_cnt != 3'd0);
        case (state_q)
            SSOpcode: rw_load   = byte_done && opcode_match(rx_byte, HW_ADDR);
            SSAddr:   addr_load = byte_done;
            SSData: begin
                if (rw_q) begin
                    tx_load_en = 1'b1;
                    addr_adv   = load_slot;
                end else begin
                    spi_we   = byte_done;
                    addr_adv = byte_done;
                end
            end
            default: ;
        endcase
    end

    assign addr_next = !AUTO_INC ? addr_q :
                       ({1'b0, addr_q} >= LAST_IDX) ? '0 : addr_q + 8'd1;

    always_ff @(posedge sysClk or negedge reset) begin
        if (!reset) begin
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= REG_RESET;
        end else begin
            wr_stb_q    <= spi_we;
            frame_err_q <= frame_err_d;
            if (spi_we) begin
                wr_addr_q <= addr_q;
                wr_data_q <= rx_byte;
            end
            if (cs_fall)      rw_q <= 1'b0;
            else if (rw_load) rw_q <= rx_byte[0];
            if (addr_load)     addr_q <= rx_byte;
            else if (addr_adv) addr_q <= addr_next;
            // SPI write takes priority over a host write to the same register.
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (spi_we && addr_q == 8'(i))               regs_q[i] <= rx_byte;
                else if (host_we_i && host_addr_i == 8'(i)) regs_q[i] <= host_wdata_i;
            end
        end
    end

    always_comb begin
        host_rdata_o = '0;
        rd_data      = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (host_addr_i == 8'(i)) host_rdata_o = regs_q[i];
            if (addr_q == 8'(i))      rd_data      = regs_q[i];
        end
    end

    assign busy_o      = (state_q != SSIdle);
    assign spi.miso    = busy_o && rw_q && (state_q == SSAddr || state_q == SSData) && tx_msb;
    assign wr_stb_o    = wr_stb_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_spi_slave_regfile.sv
// Randomised self-checking bench for spi_slave_regfile against a byte-level register model.
module tb_spi_slave_regfile;
    localparam int NR   = 22;
    localparam int HALF = 8;

    logic sysClk = 1'b0;
    logic reset  = 1'b0;
    always #5 sysClk = ~sysClk;

    logic       sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0, h2_addr = '0;
    logic       host_we = 1'b0;
    logic [7:0] host_rdata, wr_addr, wr_data, h2_rdata, h2_wa, h2_wd;
    logic       wr_stb, busy, frame_err, h2_stb, h2_busy, h2_ferr;

    spi_slave_regfile_if spi0();
    spi_slave_regfile_if spi1();
    assign spi0.spiClk = sclk;
    assign spi0.cs     = csn;
    assign spi0.mosi   = mosi;
    assign spi1.spiClk = sclk;
    assign spi1.cs     = csn;
    assign spi1.mosi   = mosi;

    spi_slave_regfile #(.NUM_REGS(NR), .HW_ADDR(3'b000), .AUTO_INC(1'b1), .REG_RESET(8'h00)) dut (
        .sysClk(sysClk), .reset(reset), .spi(spi0.slave),
        .host_addr_i(host_addr), .host_rdata_o(host_rdata), .host_we_i(host_we), .host_wdata_i(host_wdata),
        .wr_stb_o(wr_stb), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy), .frame_err_o(frame_err));

    spi_slave_regfile #(.NUM_REGS(NR), .HW_ADDR(3'b000), .AUTO_INC(1'b0), .REG_RESET(8'h00)) dut_noinc (
        .sysClk(sysClk), .reset(reset), .spi(spi1.slave),
        .host_addr_i(h2_addr), .host_rdata_o(h2_rdata), .host_we_i(1'b0), .host_wdata_i(8'h00),
        .wr_stb_o(h2_stb), .wr_addr_o(h2_wa), .wr_data_o(h2_wd), .busy_o(h2_busy), .frame_err_o(h2_ferr));

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model [256];
    logic [7:0] wa_obs[$], wd_obs[$];
    int ferr_cnt = 0;
    logic [7:0] txq[$];

    always @(negedge sysClk) begin
        if (wr_stb) begin
            wa_obs.push_back(wr_addr);
            wd_obs.push_back(wr_data);
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mread(input logic [7:0] a);
        return (int'(a) < NR) ? model[a] : 8'h00;
    endfunction

    function automatic logic [7:0] madv(input logic [7:0] a);
        return (int'(a) >= NR - 1) ? 8'h00 : a + 8'd1;
    endfunction

    task automatic sweep(input string tag);
        for (int a = 0; a < NR + 2; a++) begin
            @(negedge sysClk);
            host_addr = 8'(a);
            #1 check(tag, host_rdata, mread(8'(a)));
        end
        host_addr = 8'hFF;
        #1 check(tag, host_rdata, 8'h00);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge sysClk);
        host_addr = a; host_wdata = d; host_we = 1'b1;
        @(negedge sysClk);
        host_we = 1'b0;
        if (int'(a) < NR) model[a] = d;
    endtask

    task automatic spi_bit(input logic b, input bit coll, input logic [7:0] ca, input logic [7:0] cd,
                           output logic s);
        mosi = b;
        repeat (HALF) @(negedge sysClk);
        s = spi0.miso;
        sclk = 1'b1;
        if (coll) begin
            // Host strobe lands on the same sysClk edge as the SPI register write.
            repeat (2) @(negedge sysClk);
            host_addr = ca; host_wdata = cd; host_we = 1'b1;
            @(negedge sysClk);
            host_we = 1'b0;
            repeat (HALF - 3) @(negedge sysClk);
        end else begin
            repeat (HALF) @(negedge sysClk);
        end
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] tx[$], input int tail, input bit coll,
                             input logic [7:0] ca, input logic [7:0] cd);
        logic [7:0] exp_rx[$], exp_wa[$], exp_wd[$];
        logic [7:0] addr, rxb;
        logic       s;
        bit         valid, rd;
        int         wbase, fbase, last;
        last  = tx.size() - 1;
        valid = ((tx[0] >> 4) == 8'd4) && (((tx[0] >> 1) & 8'd7) == 8'd0);
        rd    = valid && (tx[0] % 2 == 1);
        addr  = (tx.size() > 1) ? tx[1] : 8'h00;
        for (int i = 0; i < tx.size(); i++) begin
            if (i < 2 || !valid) begin
                exp_rx.push_back(8'h00);
            end else if (rd) begin
                exp_rx.push_back(mread(addr));
                addr = madv(addr);
            end else begin
                if (coll && i == last && int'(ca) < NR) model[ca] = cd;
                if (int'(addr) < NR) model[addr] = tx[i];
                exp_wa.push_back(addr);
                exp_wd.push_back(tx[i]);
                addr = madv(addr);
            end
        end
        wbase = wa_obs.size();
        fbase = ferr_cnt;
        @(negedge sysClk);
        csn = 1'b0;
        repeat (HALF) @(negedge sysClk);
        check("busy_on", busy, 1);
        for (int i = 0; i < tx.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                spi_bit(tx[i][b], coll && i == last && b == 0, ca, cd, s);
                rxb[b] = s;
            end
            check("miso_byte", rxb, exp_rx[i]);
        end
        for (int t = 0; t < tail; t++) spi_bit(1'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00, s);
        repeat (HALF) @(negedge sysClk);
        csn = 1'b1;
        repeat (HALF) @(negedge sysClk);
        check("busy_off", busy, 0);
        check("frame_err_pulses", ferr_cnt - fbase, (tail > 0) ? 1 : 0);
        check("wr_count", wa_obs.size() - wbase, exp_wa.size());
        for (int k = 0; k < exp_wa.size() && wbase + k < wa_obs.size(); k++) begin
            check("wr_addr", wa_obs[wbase + k], exp_wa[k]);
            check("wr_data", wd_obs[wbase + k], exp_wd[k]);
        end
    endtask

    initial begin
        logic [7:0] op;
        logic       s;
        int         tail, wbase, fbase;
        for (int a = 0; a < 256; a++) model[a] = 8'h00;

        repeat (3) @(negedge sysClk);
        check("rst_miso", spi0.miso, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        reset = 1'b1;
        repeat (4) @(negedge sysClk);

        txq = {8'h40, 8'h0A, 8'h28};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);
        sweep("burst_reg");

        host_write(8'h00, 8'hF9);
        host_write(8'h01, 8'hE4);
        txq = {8'h41, 8'h00, 8'h00, 8'h00};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);

        txq = {8'h40, 8'h15, 8'hAA, 8'hBB};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);
        sweep("wrap_reg");
        @(negedge sysClk);
        h2_addr = 8'd21;
        #1 check("noinc_reg21", h2_rdata, 8'hBB);

        txq = {8'h42, 8'h00, 8'h55};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);

        txq = {8'h40, 8'h0A};
        spi_frame(txq, 3, 1'b0, 8'h00, 8'h00);
        txq = {8'h40, 8'h0A, 8'h11};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);
        sweep("abort_reg");

        txq = {8'h40, 8'h0A, 8'h28};
        spi_frame(txq, 0, 1'b1, 8'h0A, 8'h77);
        txq = {8'h40, 8'h0B, 8'h5C};
        spi_frame(txq, 0, 1'b1, 8'h0C, 8'h33);
        sweep("collide_reg");

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) host_write(8'($urandom_range(0, NR + 1)), 8'($urandom));
            op = ($urandom_range(0, 4) == 0) ? 8'($urandom) : {7'b0100000, 1'($urandom_range(0, 1))};
            txq = {op};
            txq.push_back(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, NR + 2)));
            repeat ($urandom_range(0, 4)) txq.push_back(8'($urandom));
            tail = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            spi_frame(txq, tail, 1'b0, 8'h00, 8'h00);
            if (n % 5 == 4) sweep("rand_reg");
        end

        txq = {8'h40, 8'h03, 8'h9D};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);
        @(negedge sysClk);
        csn = 1'b0;
        repeat (HALF) @(negedge sysClk);
        op = 8'h40;
        for (int b = 7; b >= 0; b--) spi_bit(op[b], 1'b0, 8'h00, 8'h00, s);
        op = 8'h05;
        for (int b = 7; b >= 0; b--) spi_bit(op[b], 1'b0, 8'h00, 8'h00, s);
        for (int b = 0; b < 3; b++) spi_bit(1'b1, 1'b0, 8'h00, 8'h00, s);
        @(negedge sysClk);
        reset = 1'b0;
        #1;
        check("mid_rst_miso", spi0.miso, 0);
        check("mid_rst_wr_stb", wr_stb, 0);
        check("mid_rst_wr_addr", wr_addr, 8'h00);
        check("mid_rst_wr_data", wr_data, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_err", frame_err, 0);
        for (int a = 0; a < 256; a++) model[a] = 8'h00;
        sweep("mid_rst_reg");
        @(negedge sysClk);
        reset = 1'b1;
        wbase = wa_obs.size();
        fbase = ferr_cnt;
        repeat (4) @(negedge sysClk);
        op = 8'h40;
        for (int b = 7; b >= 0; b--) spi_bit(op[b], 1'b0, 8'h00, 8'h00, s);
        for (int b = 0; b < 2; b++) spi_bit(1'b0, 1'b0, 8'h00, 8'h00, s);
        check("post_rst_idle", busy, 0);
        repeat (HALF) @(negedge sysClk);
        csn = 1'b1;
        repeat (HALF) @(negedge sysClk);
        check("post_rst_no_ferr", ferr_cnt - fbase, 0);
        check("post_rst_no_wr", wa_obs.size() - wbase, 0);

        txq = {8'h40, 8'h12, 8'h5A};
        spi_frame(txq, 0, 1'b0, 8'h00, 8'h00);
        sweep("final_reg");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
